// File: rtl/i2c_reg_ctrl.sv
// ============================================================================
// i2c_reg_ctrl
//
// Oversampled I2C slave that turns bus transactions into single-cycle
// register-bank accesses. Everything runs on clk_i; SCL/SDA are treated as
// ordinary asynchronous inputs and sampled.
//
// Transaction format:
//   START, {SLAVE_ADDR, R/W}, pointer byte, data bytes...    (write)
//   START, {SLAVE_ADDR, 0}, pointer, START, {SLAVE_ADDR, 1}  (pointer-then-read)
// The pointer auto-increments after each data byte and wraps at 2**ADDR_W.
//
// Ports:
//   clk_i        system clock, at least 16x the SCL frequency
//   rst_i        synchronous, active-high reset
//   scl_i        raw SCL from the pad
//   sda_i        raw SDA from the pad
//   sda_oe_o     1 = pull SDA low (open drain), 0 = release
//   reg_addr_o   register pointer for the current access
//   reg_wdata_o  write data, valid while reg_we_o is high
//   reg_we_o     one-clock write strobe
//   reg_re_o     one-clock read strobe; reg_rdata_i is taken one clock later
//   reg_rdata_i  read data from the bank, one-clock latency after reg_re_o
//   busy_o       high while a transaction addressed to this slave is active
//
// Build option:
//   I2C_GLITCH_FILTER_EN  when defined, a 3-sample agreement filter follows
//                         the synchroniser on each line (rejects spikes of up
//                         to 2 clocks, adds 2 clocks of latency).
// ============================================================================
module i2c_reg_ctrl #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h5A,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              busy_o
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser. Idle bus level is high, so the flops reset to 1
    // to avoid a false START/STOP right after reset.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

    logic scl_lvl;
    logic sda_lvl;

`ifdef I2C_GLITCH_FILTER_EN
    // Level follows the input only once three consecutive samples agree.
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_filt_q;
    logic       sda_filt_q;

    // NOTE: both outputs get a value on every path, so no latch is inferred.
    always_comb begin
        scl_lvl = scl_filt_q;
        sda_lvl = sda_filt_q;
        if (scl_sync_q[SYNC_STAGES-1] == scl_hist_q[0] && scl_hist_q[0] == scl_hist_q[1]) begin
            scl_lvl = scl_hist_q[0];
        end
        if (sda_sync_q[SYNC_STAGES-1] == sda_hist_q[0] && sda_hist_q[0] == sda_hist_q[1]) begin
            sda_lvl = sda_hist_q[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
            scl_filt_q <= scl_lvl;
            sda_filt_q <= sda_lvl;
        end
    end
`else
    assign scl_lvl = scl_sync_q[SYNC_STAGES-1];
    assign sda_lvl = sda_sync_q[SYNC_STAGES-1];
`endif

    // ------------------------------------------------------------------
    // Edge and bus-condition detection against the previous sample.
    // ------------------------------------------------------------------
    logic scl_prev_q;
    logic sda_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_lvl;
            sda_prev_q <= sda_lvl;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  =  scl_lvl & ~scl_prev_q;
    assign scl_fall  = ~scl_lvl &  scl_prev_q;
    assign start_det =  scl_lvl &  scl_prev_q &  sda_prev_q & ~sda_lvl;
    assign stop_det  =  scl_lvl &  scl_prev_q & ~sda_prev_q &  sda_lvl;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [2:0]        bit_cnt_q;
    logic              byte_done_q;  // 8th bit of the current byte handled
    logic [7:0]        shift_q;
    logic              rw_q;
    logic              ack_q;        // master ACKed; reload pending for next byte
    logic              rd_pend_q;    // reg_rdata_i valid this clock
    logic              inc_pend_q;   // pointer bump one clock after reg_we
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        wdata_q;
    logic              we_q;
    logic              re_q;
    logic              sda_oe_q;

    logic rx_state;
    logic byte_fall;

    assign rx_state  = (state_q == ST_ADDR) || (state_q == ST_PTR) || (state_q == ST_WDATA);
    assign byte_fall = scl_fall & byte_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd7;
            byte_done_q <= 1'b0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            rd_pend_q   <= 1'b0;
            inc_pend_q  <= 1'b0;
            ptr_q       <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            inc_pend_q <= 1'b0;
            rd_pend_q  <= re_q;

            if (rd_pend_q) begin
                shift_q <= reg_rdata_i;
            end
            if (inc_pend_q) begin
                ptr_q <= ptr_q + 1'b1;
            end

            // Receive shifter, shared by the three byte-receiving states.
            if (rx_state && scl_rise) begin
                shift_q   <= {shift_q[6:0], sda_lvl};
                bit_cnt_q <= bit_cnt_q - 3'd1;
                if (bit_cnt_q == 3'd0) begin
                    byte_done_q <= 1'b1;
                end
            end

            if (stop_det) begin
                state_q     <= ST_IDLE;
                sda_oe_q    <= 1'b0;
                bit_cnt_q   <= 3'd7;
                byte_done_q <= 1'b0;
            end else if (start_det) begin
                state_q     <= ST_ADDR;
                sda_oe_q    <= 1'b0;
                bit_cnt_q   <= 3'd7;
                byte_done_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (byte_fall) begin
                            byte_done_q <= 1'b0;
                            rw_q        <= shift_q[0];
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                state_q  <= ST_ADDR_ACK;
                                sda_oe_q <= 1'b1;
                                re_q     <= shift_q[0];
                            end else begin
                                state_q <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw_q) begin
                                // shift_q already holds the fetched byte; drive its MSB.
                                state_q   <= ST_RDATA;
                                sda_oe_q  <= ~shift_q[7];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= 3'd6;
                            end else begin
                                state_q   <= ST_PTR;
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 3'd7;
                            end
                        end
                    end
                    ST_PTR: begin
                        if (byte_fall) begin
                            byte_done_q <= 1'b0;
                            ptr_q       <= shift_q[ADDR_W-1:0];
                            sda_oe_q    <= 1'b1;
                            state_q     <= ST_PTR_ACK;
                        end
                    end
                    ST_WDATA: begin
                        if (byte_fall) begin
                            byte_done_q <= 1'b0;
                            we_q        <= 1'b1;
                            wdata_q     <= shift_q;
                            inc_pend_q  <= 1'b1;
                            sda_oe_q    <= 1'b1;
                            state_q     <= ST_WDATA_ACK;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_WDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_fall) begin
                            if (byte_done_q) begin
                                byte_done_q <= 1'b0;
                                sda_oe_q    <= 1'b0;
                                ptr_q       <= ptr_q + 1'b1;
                                ack_q       <= 1'b0;
                                state_q     <= ST_RDATA_ACK;
                            end else begin
                                sda_oe_q  <= ~shift_q[7];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q - 3'd1;
                                if (bit_cnt_q == 3'd0) begin
                                    byte_done_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_lvl) begin
                                re_q  <= 1'b1;
                                ack_q <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall && ack_q) begin
                            ack_q     <= 1'b0;
                            state_q   <= ST_RDATA;
                            sda_oe_q  <= ~shift_q[7];
                            shift_q   <= {shift_q[6:0], 1'b0};
                            bit_cnt_q <= 3'd6;
                        end
                    end
                    ST_IDLE, ST_WAIT_STOP: begin
                        sda_oe_q <= 1'b0;
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign reg_addr_o  = ptr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign reg_re_o    = re_q;
    assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_WAIT_STOP);

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// ============================================================================
// tb_i2c_reg_ctrl
//
// Bench for i2c_reg_ctrl. A bus-functional I2C master drives SCL/SDA; a
// register-bank model answers reg_we/reg_re. The reference model (pointer +
// memory array) predicts every bank strobe and pushes it into a queue; a
// monitor pops and compares whenever the DUT strobes. Bytes read back over
// SDA and ACK slots are compared against the model directly.
// ============================================================================
module tb_i2c_reg_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scl_m = 1'b1;
    logic          sda_m = 1'b1;
    logic          sda_bus;
    logic          sda_oe;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_we;
    logic          reg_re;
    logic [7:0]    reg_rdata = 8'h00;
    logic          busy;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_reg_ctrl #(
        .SLAVE_ADDR (7'h5A),
        .ADDR_W     (AW),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe),
        .reg_addr_o (reg_addr),
        .reg_wdata_o(reg_wdata),
        .reg_we_o   (reg_we),
        .reg_re_o   (reg_re),
        .reg_rdata_i(reg_rdata),
        .busy_o     (busy)
    );

    // ---------------- bank attached to the DUT ----------------
    logic [7:0] bank [DEPTH];
    always @(posedge clk) begin
        if (reg_we) bank[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= bank[reg_addr];
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic          is_we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_mem [DEPTH];
    int         model_ptr = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       oe_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic is_we, input int addr, input logic [7:0] data);
        exp_t e;
        e.is_we = is_we;
        e.addr  = AW'(addr);
        e.data  = data;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (sda_oe) oe_seen = 1'b1;
            if (reg_we || reg_re) begin
                if (exp_q.size() == 0) begin
                    check("unexpected strobe {we,re}", {30'd0, reg_we, reg_re}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("strobe kind {we,re}", {30'd0, reg_we, reg_re}, e.is_we ? 32'd2 : 32'd1);
                    check("strobe addr", {28'd0, reg_addr}, {28'd0, e.addr});
                    if (e.is_we) check("write data", {24'd0, reg_wdata}, {24'd0, e.data});
                end
            end
        end
    end

    // ---------------- I2C master BFM ----------------
    task automatic q();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    // glitch=1 inserts a one-clock low spike on SCL while it is high.
    task automatic wbit(input logic b, input bit glitch);
        sda_m = b; q();
        scl_m = 1'b1;
        if (glitch) begin
            repeat (2) @(posedge clk);
            #1 scl_m = 1'b0;
            @(posedge clk);
            #1 scl_m = 1'b1;
        end
        q(); q();
        scl_m = 1'b0; q();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        b = sda_bus;
        q();
        scl_m = 1'b0; q();
    endtask

    task automatic wbyte(input logic [7:0] d, input int glitch_at, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i], (i == glitch_at));
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
    endtask

    // ---------------- transactions in model terms ----------------
    task automatic do_write(input logic [7:0] ptr, input logic [7:0] data[$]);
        logic ack;
        i2c_start();
        wbyte(8'hB4, -1, ack); check("write addr ack", {31'd0, ack}, 32'd0);
        check("busy during write", {31'd0, busy}, 32'd1);
        wbyte(ptr, -1, ack);   check("pointer ack", {31'd0, ack}, 32'd0);
        model_ptr = ptr % DEPTH;
        foreach (data[k]) begin
            exp_q.push_back(mk(1'b1, model_ptr, data[k]));
            model_mem[model_ptr] = data[k];
            wbyte(data[k], -1, ack); check("data ack", {31'd0, ack}, 32'd0);
            model_ptr = (model_ptr + 1) % DEPTH;
        end
        i2c_stop();
        settle();
        check("busy after write stop", {31'd0, busy}, 32'd0);
        check("pointer after write", {28'd0, reg_addr}, model_ptr);
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n);
        logic       ack;
        logic [7:0] got;
        i2c_start();
        wbyte(8'hB4, -1, ack); check("read-setup addr ack", {31'd0, ack}, 32'd0);
        wbyte(ptr, -1, ack);   check("read-setup pointer ack", {31'd0, ack}, 32'd0);
        model_ptr = ptr % DEPTH;
        i2c_start();
        exp_q.push_back(mk(1'b0, model_ptr, 8'h00));
        wbyte(8'hB5, -1, ack); check("read addr ack", {31'd0, ack}, 32'd0);
        for (int k = 0; k < n; k++) begin
            rbyte(got);
            check("read byte", {24'd0, got}, {24'd0, model_mem[model_ptr]});
            model_ptr = (model_ptr + 1) % DEPTH;
            if (k < n - 1) begin
                exp_q.push_back(mk(1'b0, model_ptr, 8'h00));
                wbit(1'b0, 1'b0);
            end else begin
                wbit(1'b1, 1'b0);
            end
        end
        settle();
        check("busy after NACK (wait-stop)", {31'd0, busy}, 32'd0);
        i2c_stop();
        settle();
    endtask

    task automatic do_mismatch(input logic [7:0] addr_byte);
        logic ack;
        oe_seen = 1'b0;
        i2c_start();
        wbyte(addr_byte, -1, ack); check("mismatch addr no-ack", {31'd0, ack}, 32'd1);
        check("busy after mismatch", {31'd0, busy}, 32'd0);
        wbyte(8'h00, -1, ack);     check("mismatch data no-ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        settle();
        check("sda_oe never driven on mismatch", {31'd0, oe_seen}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] dq[$];
        logic       ack;
        logic [7:0] v;

        for (int i = 0; i < DEPTH; i++) begin
            v = 8'($urandom);
            bank[i]      = v;
            model_mem[i] = v;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset sda_oe", {31'd0, sda_oe}, 32'd0);
        check("reset reg_addr", {28'd0, reg_addr}, 32'd0);
        check("reset reg_wdata", {24'd0, reg_wdata}, 32'd0);
        check("reset reg_we", {31'd0, reg_we}, 32'd0);
        check("reset reg_re", {31'd0, reg_re}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        settle();

        // Single write at pointer 3.
        dq = {8'hA5};
        do_write(8'h03, dq);

        // Pointer wrap 0xF -> 0x0.
        dq = {8'h11, 8'h22};
        do_write(8'h0F, dq);

        // Pointer-then-read with repeated start.
        dq = {8'hBE, 8'hEF};
        do_write(8'h02, dq);
        do_read(8'h02, 2);

        // Address mismatch.
        do_mismatch(8'h78);

        // Abort: STOP after 4 bits of a data byte.
        i2c_start();
        wbyte(8'hB4, -1, ack); check("abort addr ack", {31'd0, ack}, 32'd0);
        wbyte(8'h05, -1, ack); check("abort pointer ack", {31'd0, ack}, 32'd0);
        model_ptr = 5;
        for (int i = 0; i < 4; i++) wbit(1'($urandom), 1'b0);
        i2c_stop();
        settle();
        check("busy after abort", {31'd0, busy}, 32'd0);
        check("no pending strobes after abort", exp_q.size(), 32'd0);
        check("pointer kept after abort", {28'd0, reg_addr}, model_ptr);

        // Reset while the slave drives a 0 bit in RDATA.
        dq = {8'h3C};
        do_write(8'h08, dq);
        i2c_start();
        wbyte(8'hB4, -1, ack);
        wbyte(8'h08, -1, ack);
        model_ptr = 8;
        i2c_start();
        exp_q.push_back(mk(1'b0, model_ptr, 8'h00));
        wbyte(8'hB5, -1, ack); check("pre-reset read ack", {31'd0, ack}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("sda_oe driving MSB before reset", {31'd0, sda_oe}, {31'd0, ~model_mem[8][7]});
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("sda_oe cleared by reset", {31'd0, sda_oe}, 32'd0);
        check("pointer cleared by reset", {28'd0, reg_addr}, 32'd0);
        rst = 1'b0;
        model_ptr = 0;
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        settle();

        // One-clock SCL spike during the address byte (bit index 6).
        oe_seen = 1'b0;
        i2c_start();
        wbyte(8'hB4, 6, ack);
`ifdef I2C_GLITCH_FILTER_EN
        check("glitch filtered addr ack", {31'd0, ack}, 32'd0);
        wbyte(8'h07, -1, ack);
        check("glitch filtered pointer ack", {31'd0, ack}, 32'd0);
        model_ptr = 7;
        i2c_stop();
        settle();
        check("pointer after filtered glitch", {28'd0, reg_addr}, model_ptr);
`else
        check("glitch misframes addr (no ack)", {31'd0, ack}, 32'd1);
        i2c_stop();
        settle();
        check("sda_oe never driven after glitch", {31'd0, oe_seen}, 32'd0);
`endif

        // Randomised transactions.
        for (int t = 0; t < 12; t++) begin
            int kind;
            int len;
            logic [7:0] p;
            kind = int'($urandom_range(0, 2));
            len  = int'($urandom_range(1, 3));
            p    = 8'($urandom);
            if (kind == 0) begin
                dq.delete();
                for (int k = 0; k < len; k++) dq.push_back(8'($urandom));
                do_write(p, dq);
            end else if (kind == 1) begin
                do_read(p, len);
            end else begin
                logic [7:0] a;
                a = 8'($urandom);
                if (a[7:1] == 7'h5A) a[7] = 1'b0;
                do_mismatch(a);
            end
        end

        settle();
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
